nibble_serial_adder_ctrl: RTL and testbench

Multi-cycle W-bit adder controller that time-shares one 4-bit carry-lookahead slice across W/4 cycles. Operands are accepted on a valid/ready handshake, sequenced nibble by nibble from LSB to MSB with a registered carry, and the result is held on a valid/ready output port until consumed. It sits between a requester (ALU sequencer or testbench) and the 4-bit adder datapath. It trades latency for area versus a full-width adder.

---
 rtl/nibble_serial_adder_ctrl_pkg.sv | 12 +
 rtl/nibble_serial_adder_ctrl_adder4.sv | 32 +++
 rtl/nibble_serial_adder_ctrl.sv | 140 ++++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package adder_ctrl_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_adder4.sv
// 4-bit carry-lookahead adder slice, time-shared by the serial controller.
module adder_4
  import adder_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_c_in,
  output logic [SLICE_W-1:0] o_sum,
  output logic               o_c_out
);

  logic [SLICE_W-1:0] w_g;
  logic [SLICE_W-1:0] w_p;
  logic [SLICE_W:0]   w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Flattened lookahead carries; no ripple between bit positions.
  assign w_c[0] = i_c_in;
  assign w_c[1] = w_g[0] | (w_p[0] & i_c_in);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c_in);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_c_in);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c_in);

  assign o_sum   = w_p ^ w_c[SLICE_W-1:0];
  assign o_c_out = w_c[SLICE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// W-bit adder built from one 4-bit slice stepped LSB-first over W/4 cycles,
// with valid/ready handshakes on operands and result.
module nibble_serial_adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         ovf,
  output logic         busy
);

  localparam int NIB = W / SLICE_W;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [W-1:0]      r_a_sr;
  logic [W-1:0]      r_b_sr;
  logic [W-1:0]      r_sum;
  logic [CW-1:0]     r_cnt;
  logic              r_carry;
  logic              r_c_out;
  logic              r_ovf;
  logic              r_a_msb;
  logic              r_b_msb;
  logic [SLICE_W-1:0] w_slice_sum;
  logic              w_slice_c;
  logic              w_last;
  logic [W-1:0]      w_sum_shift;

  adder_4 u_slice (
    .i_a     (r_a_sr[SLICE_W-1:0]),
    .i_b     (r_b_sr[SLICE_W-1:0]),
    .i_c_in  (r_carry),
    .o_sum   (w_slice_sum),
    .o_c_out (w_slice_c)
  );

  assign w_last = (r_cnt == CNT_LAST);

  // New nibble enters at the top so the LSB nibble ends at bit 0 after NIB steps.
  generate
    if (W == SLICE_W) begin : g_single
      assign w_sum_shift = w_slice_sum;
    end else begin : g_multi
      assign w_sum_shift = {w_slice_sum, r_sum[W-1:SLICE_W]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) w_state_nxt = S_RUN;
        else          w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
        else        w_state_nxt = S_RUN;
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
        else           w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand load, per-nibble shift/accumulate, result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= c_in;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_a_msb <= a[W-1];
            r_b_msb <= b[W-1];
          end
        end
        S_RUN: begin
          r_a_sr  <= r_a_sr >> SLICE_W;
          r_b_sr  <= r_b_sr >> SLICE_W;
          r_carry <= w_slice_c;
          r_cnt   <= r_cnt + CW'(1);
          r_sum   <= w_sum_shift;
          if (w_last) begin
            r_c_out <= w_slice_c;
            r_ovf   <= (r_a_msb == r_b_msb) && (w_slice_sum[SLICE_W-1] != r_a_msb);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign sum       = r_sum;
  assign c_out     = r_c_out;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for the nibble-serial adder: W=32 and W=4 instances.
module tb_nibble_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, c_in, out_valid, out_ready, c_out, ovf, busy;
  logic [31:0] a, b, sum;

  logic        in_valid_4, in_ready_4, c_in_4, out_valid_4, out_ready_4;
  logic        c_out_4, ovf_4, busy_4;
  logic [3:0]  a_4, b_4, sum_4;

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;
  int acc_cyc;
  int prev_acc;

  logic [31:0] m_sum;
  logic        m_c, m_o;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_serial_adder_ctrl #(.W(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf), .busy(busy)
  );

  nibble_serial_adder_ctrl #(.W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_4), .in_ready(in_ready_4),
    .a(a_4), .b(b_4), .c_in(c_in_4), .out_valid(out_valid_4), .out_ready(out_ready_4),
    .sum(sum_4), .c_out(c_out_4), .ovf(ovf_4), .busy(busy_4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [31:0] x, input logic [31:0] y, input logic ci);
    logic [32:0] t;
    t = {1'b0, x} + {1'b0, y} + {32'd0, ci};
    m_sum = t[31:0];
    m_c   = t[32];
    m_o   = (x[31] == y[31]) && (t[31] != x[31]);
  endtask

  // Called on a negedge in IDLE; returns on the negedge after the accept edge.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic ci);
    chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    a = x; b = y; c_in = ci; in_valid = 1'b1;
    @(negedge clk);
    acc_cyc = cyc;
    in_valid = 1'b0; a = $urandom; b = $urandom; c_in = 1'b1;
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    chk("sum_cleared_on_load", {32'd0, sum}, 64'd0);
  endtask

  task automatic wait_done(input int exp_lat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, exp_lat);
  endtask

  task automatic chk_result(input string tag, input logic [31:0] s, input logic c, input logic o);
    chk({tag, "_sum"}, {32'd0, sum}, {32'd0, s});
    chk({tag, "_c_out"}, {63'd0, c_out}, {63'd0, c});
    chk({tag, "_ovf"}, {63'd0, ovf}, {63'd0, o});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = 32'd0; b = 32'd0; c_in = 1'b0;
    in_valid_4 = 1'b0; out_ready_4 = 1'b1; a_4 = 4'd0; b_4 = 4'd0; c_in_4 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sum", {32'd0, sum}, 64'd0);
    chk("rst_flags", {59'd0, c_out, ovf, out_valid, busy, in_ready}, 64'h1);
    chk("rst_w4", {56'd0, sum_4, out_valid_4, busy_4, in_ready_4, c_out_4}, 64'h2);
    rst_n = 1'b1;
    @(negedge clk);

    // Wrap-around to zero with carry out.
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done(8);
    chk_result("ffff_plus_1", 32'h0000_0000, 1'b1, 1'b0);
    @(negedge clk);
    chk("idle_after_handshake", {62'd0, in_ready, out_valid}, 64'h2);
    chk("c_out_held_in_idle", {63'd0, c_out}, 64'd1);

    // Signed overflow, then a carry-in case.
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done(8);
    chk_result("signed_ovf", 32'h8000_0000, 1'b0, 1'b1);
    @(negedge clk);
    issue(32'h1234_5678, 32'h0FED_CBA9, 1'b1);
    wait_done(8);
    chk_result("carry_in", 32'h2222_2222, 1'b0, 1'b0);
    @(negedge clk);

    // Consumer stall with a persistent requester.
    out_ready = 1'b0;
    issue(32'h0000_0003, 32'h0000_0004, 1'b0);
    wait_done(8);
    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom; c_in = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_sum", {32'd0, sum}, 64'd7);
    end
    out_ready = 1'b1; a = 32'h0000_0100; b = 32'h0000_0200; c_in = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    chk("release_idle", {62'd0, in_ready, out_valid}, 64'h2);
    chk("release_sum_held", {32'd0, sum}, 64'd7);
    @(negedge clk);
    in_valid = 1'b0;
    chk("second_accepted", {62'd0, busy, in_ready}, 64'h2);
    wait_done(8);
    chk_result("second_op", 32'h0000_0300, 1'b0, 1'b0);
    @(negedge clk);

    // Asynchronous reset during the third RUN cycle.
    issue(32'hFFFF_0000, 32'h0000_1234, 1'b0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrun_rst_flags", {61'd0, out_valid, busy, in_ready}, 64'h1);
    chk("midrun_rst_sum", {32'd0, sum}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_flags", {61'd0, out_valid, busy, in_ready}, 64'h1);
    issue(32'h0000_0005, 32'h0000_0003, 1'b0);
    wait_done(8);
    chk_result("after_reset", 32'h0000_0008, 1'b0, 1'b0);
    @(negedge clk);

    // Back-to-back at minimum issue interval.
    prev_acc = 0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] x, y;
      logic        ci;
      x = $urandom; y = $urandom; ci = 1'($urandom_range(0, 1));
      model(x, y, ci);
      issue(x, y, ci);
      if (i > 0) chk("issue_interval", acc_cyc - prev_acc, 10);
      prev_acc = acc_cyc;
      wait_done(8);
      chk_result("b2b", m_sum, m_c, m_o);
      @(negedge clk);
    end

    // W=4: single RUN cycle.
    a_4 = 4'hF; b_4 = 4'h1; c_in_4 = 1'b1; in_valid_4 = 1'b1;
    @(negedge clk);
    in_valid_4 = 1'b0;
    chk("w4_run", {62'd0, busy_4, out_valid_4}, 64'h2);
    @(negedge clk);
    chk("w4_out_valid", {63'd0, out_valid_4}, 64'd1);
    chk("w4_result", {58'd0, sum_4, c_out_4, ovf_4}, 64'h6);
    @(negedge clk);
    chk("w4_idle", {63'd0, in_ready_4}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
